// File: rtl/dsp_sop_array_acc.sv
// Multi-channel signed sum-of-products with optional frame accumulation.
// Three-stage pipeline (operands, products, sum/accumulate) with a shared valid/ready handshake.
module dsp_sop_array_acc #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned IN_W   = 18,
  parameter int unsigned OUT_W  = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*4*IN_W-1:0] inp,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [7:0]               acc_len,
  output logic [NUM_CH*OUT_W-1:0]  outp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        sat
);

  localparam int unsigned CW = 4 * IN_W;
  localparam int unsigned PW = 2 * IN_W;
  localparam int unsigned SW = OUT_W + 2;

  logic stall, adv, accept;
  logic first, m_eff, last_in;
  logic [7:0] len_new, len_eff;

  // Shared control: stage valids plus per-sample mode/last tags travelling with the data
  logic       v1, m1, l1, v2, m2, l2;
  logic [7:0] cnt_in, cnt3, len_l;
  logic       mode_l;
  logic [NUM_CH*CW-1:0] d1;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = reset & adv;
  assign accept   = in_valid & in_ready;

  // Frame parameters are taken from the ports only on the first sample of a frame
  always_comb begin
    first   = (cnt_in == 8'd0);
    len_new = (acc_len == 8'd0) ? 8'd1 : acc_len;
    m_eff   = first ? mode : mode_l;
    len_eff = first ? len_new : len_l;
    last_in = ~m_eff | (cnt_in == (len_eff - 8'd1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      m1        <= 1'b0;
      l1        <= 1'b0;
      v2        <= 1'b0;
      m2        <= 1'b0;
      l2        <= 1'b0;
      out_valid <= 1'b0;
      cnt_in    <= 8'd0;
      cnt3      <= 8'd0;
      mode_l    <= 1'b0;
      len_l     <= 8'd1;
      d1        <= '0;
    end else if (adv) begin
      v1 <= accept;
      if (accept) begin
        d1     <= inp;
        m1     <= m_eff;
        l1     <= last_in;
        cnt_in <= last_in ? 8'd0 : (cnt_in + 8'd1);
        if (first) begin
          mode_l <= mode;
          len_l  <= len_new;
        end
      end
      v2        <= v1;
      m2        <= m1;
      l2        <= l1;
      out_valid <= v2 & l2;
      if (v2) cnt3 <= l2 ? 8'd0 : (cnt3 + 8'd1);
    end
  end

  // Frame counter at the accumulate stage is kept for observability only
  logic unused_cnt3;
  assign unused_cnt3 = ^cnt3;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [IN_W-1:0]  a0, b0, a1, b1;
    logic signed [PW-1:0]    p0, p1;
    logic signed [OUT_W-1:0] acc;
    logic                    sacc;
    logic signed [SW-1:0]    sum;
    logic                    ovf;
    logic [OUT_W-1:0]        clamped;
    logic [OUT_W-1:0]        outp_r;
    logic                    sat_r;

    assign a0 = d1[c*CW          +: IN_W];
    assign b0 = d1[c*CW + IN_W   +: IN_W];
    assign a1 = d1[c*CW + 2*IN_W +: IN_W];
    assign b1 = d1[c*CW + 3*IN_W +: IN_W];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        p0 <= '0;
        p1 <= '0;
      end else if (adv && v1) begin
        p0 <= PW'(a0) * PW'(b0);
        p1 <= PW'(a1) * PW'(b1);
      end
    end

    // Wide sum, then clamp when the top three bits disagree
    always_comb begin
      sum = SW'(p0) + SW'(p1);
      if (m2) sum = sum + SW'(acc);
      ovf = (sum[SW-1:OUT_W-1] != {3{sum[SW-1]}});
      clamped = sum[OUT_W-1:0];
      if (ovf) clamped = sum[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end

    // Saturation flag is sticky across an accumulated frame
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc    <= '0;
        sacc   <= 1'b0;
        outp_r <= '0;
        sat_r  <= 1'b0;
      end else if (adv && v2) begin
        if (l2) begin
          outp_r <= clamped;
          sat_r  <= ovf | (m2 & sacc);
          acc    <= '0;
          sacc   <= 1'b0;
        end else begin
          acc  <= clamped;
          sacc <= sacc | ovf;
        end
      end
    end

    assign outp[c*OUT_W +: OUT_W] = outp_r;
    assign sat[c]                 = sat_r;
  end

endmodule
